// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolution signal bundle for branch_predictor.
// The pipeline side (master) drives PCs and resolutions; the predictor (slave) answers.
interface branch_predictor_if;
  logic [31:0] pc_fetch;
  logic        predict_taken;
  logic [31:0] next_pc;

  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_predicted_taken;
  logic [31:0] update_predicted_target;

  logic        mispredict;
  logic [31:0] correct_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  modport master (
    output pc_fetch,
    output update_valid, update_pc, update_taken, update_target,
    output update_predicted_taken, update_predicted_target,
    input  predict_taken, next_pc, mispredict, correct_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  pc_fetch,
    input  update_valid, update_pc, update_taken, update_target,
    input  update_predicted_taken, update_predicted_target,
    output predict_taken, next_pc, mispredict, correct_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency next-PC prediction
// in fetch, resolution/redirect and table training from execute, plus hit statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  branch_predictor_if.slave   bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      STRONG_NT: ctr_inc = WEAK_NT;
      WEAK_NT:   ctr_inc = WEAK_T;
      default:   ctr_inc = STRONG_T;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      STRONG_T: ctr_dec = WEAK_T;
      WEAK_T:   ctr_dec = WEAK_NT;
      default:  ctr_dec = STRONG_NT;
    endcase
  endfunction

  logic        valid_q  [ENTRIES];
  tag_t        tag_q    [ENTRIES];
  ctr_e        ctr_q    [ENTRIES];
  logic [31:0] target_q [ENTRIES];

  logic [15:0] branch_count_q;
  logic [15:0] mispredict_count_q;

  idx_t fetch_idx;
  tag_t fetch_tag;
  idx_t upd_idx;
  tag_t upd_tag;
  logic fetch_hit;
  logic upd_hit;
  logic mispredict;
  logic predict_taken;

  assign fetch_idx = bus.pc_fetch[INDEX_BITS-1:0];
  assign fetch_tag = bus.pc_fetch[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign upd_idx   = bus.update_pc[INDEX_BITS-1:0];
  assign upd_tag   = bus.update_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];

  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign predict_taken = fetch_hit && ctr_q[fetch_idx][1];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bus.next_pc    = bus.pc_fetch + 32'd1;
    bus.correct_pc = bus.update_pc + 32'd1;
    mispredict     = 1'b0;
    if (predict_taken) begin
      bus.next_pc = target_q[fetch_idx];
    end
    if (bus.update_taken) begin
      bus.correct_pc = bus.update_target;
    end
    if (bus.update_valid) begin
      mispredict = (bus.update_predicted_taken != bus.update_taken) ||
                   (bus.update_taken && (bus.update_predicted_target != bus.update_target));
    end
  end

  assign bus.predict_taken    = predict_taken;
  assign bus.mispredict       = mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  // NOTE: the table is reset entry by entry because a cleared BTB must never hit,
  // and its counters must restart at weak-not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= WEAK_NT;
        target_q[i] <= '0;
      end
    end else if (bus.update_valid) begin
      // NOTE: non-blocking assignments keep all table fields updating off the old values.
      if (upd_hit) begin
        if (bus.update_taken) begin
          ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
          target_q[upd_idx] <= bus.update_target;
        end else begin
          ctr_q[upd_idx]    <= ctr_dec(ctr_q[upd_idx]);
        end
      end else if (bus.update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        ctr_q[upd_idx]    <= WEAK_T;
        target_q[upd_idx] <= bus.update_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.update_valid) begin
      if (branch_count_q != 16'hFFFF) begin
        branch_count_q <= branch_count_q + 16'd1;
      end
      if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

endmodule
